// File: rtl/vector_pkg.sv
// vector_pkg: vector entry layout, terminator and scheduler state encoding.
package vector_pkg;
  localparam int X_LSB = 10;
  localparam int Y_LSB = 2;
  localparam int LINE_BIT = 1;
  localparam int POS_BIT = 0;
  localparam logic [17:0] TERMINATOR = {8'd0, 8'd0, 1'b1, 1'b1};
  typedef enum logic [2:0] {
    FILL   = 3'd0,
    READY  = 3'd1,
    SWAP   = 3'd2,
    REL_LO = 3'd3,
    REL_HI = 3'd4
  } sched_state_t;
endpackage

// File: rtl/vector_bank_ram.sv
// vector_bank_ram: simple dual-port RAM with one-cycle synchronous read.
module vector_bank_ram #(
  parameter int AW = 10,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/vector_frame_sched.sv
// vector_frame_sched: double-buffered vector list; swaps banks only at consumer frame boundaries.
module vector_frame_sched
  import vector_pkg::*;
#(
  parameter int ADR_WIDTH = 16,
  parameter int DATAWIDTH = 18,
  parameter int BANK_AW = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADR_WIDTH-1:0] wr_adr,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 prod_go,
  output logic                 prod_halt,
  input  logic [BANK_AW-1:0]   rd_adr,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 cons_start,
  input  logic                 cons_done,
  output logic [BANK_AW:0]     front_len,
  output logic [15:0]          swap_count,
  output logic                 overflow,
  output logic [2:0]           state_debug
);
  sched_state_t state;
  logic front_sel, front_valid, armed, done_pend, rd_sel, rd_ok;
  logic [ADR_WIDTH-1:0] base, last_adr, off;
  logic [BANK_AW:0] back_len;
  logic [DATAWIDTH-1:0] q0, q1;
  logic wr_en, in_range, done_in, done_any;
  assign off = wr_adr - base - ADR_WIDTH'(1);
  assign in_range = off[ADR_WIDTH-1:BANK_AW] == '0;
  assign wr_en = state == FILL && wr_adr != last_adr;
  assign done_in = cons_done && front_valid;
  assign done_any = done_in || done_pend;
  assign state_debug = state;
  assign rd_data = rd_ok ? (rd_sel ? q1 : q0) : '0;
  // writes always target the bank the consumer is not reading
  vector_bank_ram #(.AW(BANK_AW), .DW(DATAWIDTH)) u_bank0 (
    .clk(clk), .we(wr_en && in_range && front_sel), .waddr(off[BANK_AW-1:0]),
    .wdata(wr_data), .raddr(rd_adr), .rdata(q0)
  );
  vector_bank_ram #(.AW(BANK_AW), .DW(DATAWIDTH)) u_bank1 (
    .clk(clk), .we(wr_en && in_range && !front_sel), .waddr(off[BANK_AW-1:0]),
    .wdata(wr_data), .raddr(rd_adr), .rdata(q1)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      prod_halt <= 1'b1;
      cons_start <= 1'b0;
      front_len <= '0;
      swap_count <= '0;
      overflow <= 1'b0;
      front_sel <= 1'b0;
      front_valid <= 1'b0;
      armed <= 1'b1;
      done_pend <= 1'b0;
      base <= '0;
      last_adr <= '0;
      back_len <= '0;
      rd_sel <= 1'b0;
      rd_ok <= 1'b0;
    end else begin
      last_adr <= wr_adr;
      cons_start <= 1'b0;
      rd_sel <= front_sel;
      rd_ok <= 1'b1;
      if (wr_en && in_range) back_len <= (BANK_AW+1)'(off[BANK_AW-1:0]) + 1'b1;
      if (wr_en && !in_range) overflow <= 1'b1;
      case (state)
        FILL: begin
          if (!prod_go) armed <= 1'b1;
          if (prod_go && armed) begin
            state <= READY;
            done_pend <= done_any;
          end else if (done_any) begin
            cons_start <= 1'b1;
            done_pend <= 1'b0;
          end
        end
        READY: if (!front_valid || done_any) begin
          state <= SWAP;
          done_pend <= 1'b0;
        end
        SWAP: begin
          state <= REL_LO;
          prod_halt <= 1'b0;
          front_sel <= !front_sel;
          front_valid <= 1'b1;
          front_len <= back_len;
          swap_count <= swap_count + 16'd1;
          cons_start <= 1'b1;
          if (done_in) done_pend <= 1'b1;
        end
        REL_LO: begin
          state <= REL_HI;
          prod_halt <= 1'b1;
          if (done_in) done_pend <= 1'b1;
        end
        REL_HI: begin
          if (done_in) done_pend <= 1'b1;
          if (!prod_go) begin
            state <= FILL;
            base <= wr_adr;
            back_len <= '0;
            armed <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_frame_sched.sv
// tb_vector_frame_sched: scenario tasks with a bank model and read-data scoreboard queue.
module tb_vector_frame_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] wr_adr = '0;
  logic [17:0] wr_data = '0;
  logic prod_go = 1'b0, cons_done = 1'b0;
  logic [2:0] rd_adr = '0;
  logic prod_halt, cons_start, overflow;
  logic [17:0] rd_data;
  logic [3:0] front_len;
  logic [15:0] swap_count;
  logic [2:0] state_debug;
  int errors = 0, checks = 0;
  logic [17:0] mdl [2][8];
  logic [17:0] exp_q [$];
  logic [17:0] exp_d;
  logic [15:0] mbase = '0;
  bit fs = 1'b0;

  vector_frame_sched #(.ADR_WIDTH(16), .DATAWIDTH(18), .BANK_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_adr(wr_adr), .wr_data(wr_data), .prod_go(prod_go),
    .prod_halt(prod_halt), .rd_adr(rd_adr), .rd_data(rd_data), .cons_start(cons_start),
    .cons_done(cons_done), .front_len(front_len), .swap_count(swap_count),
    .overflow(overflow), .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pwrite(input logic [15:0] a);
    logic [15:0] o;
    logic [17:0] d;
    d = 18'($urandom);
    o = a - mbase - 16'd1;
    if (o < 16'd8) mdl[!fs][o[2:0]] = d;
    wr_adr = a;
    wr_data = d;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (prod_halt !== 1'b1) begin errors++; $display("FAIL reset_halt: got %0h want 1", prod_halt); end
    checks++; if (cons_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0h want 0", cons_start); end
    checks++; if (front_len !== 4'd0) begin errors++; $display("FAIL reset_len: got %0h want 0", front_len); end
    checks++; if (swap_count !== 16'd0) begin errors++; $display("FAIL reset_swaps: got %0h want 0", swap_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0h want 0", overflow); end
    checks++; if (rd_data !== 18'd0) begin errors++; $display("FAIL reset_rd: got %0h want 0", rd_data); end
    checks++; if (state_debug !== 3'd0) begin errors++; $display("FAIL reset_state: got %0h want 0", state_debug); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_powerup;
    for (int a = 1; a <= 5; a++) pwrite(16'(a));
    prod_go = 1'b1;
    tick();
    checks++; if (state_debug !== 3'd1) begin errors++; $display("FAIL pu_ready: got %0h want 1", state_debug); end
    tick();
    checks++; if (state_debug !== 3'd2) begin errors++; $display("FAIL pu_swap: got %0h want 2", state_debug); end
    checks++; if (prod_halt !== 1'b1) begin errors++; $display("FAIL pu_halt_swap: got %0h want 1", prod_halt); end
    tick();
    fs = !fs;
    checks++; if (prod_halt !== 1'b0) begin errors++; $display("FAIL pu_halt_rel: got %0h want 0", prod_halt); end
    checks++; if (cons_start !== 1'b1) begin errors++; $display("FAIL pu_start: got %0h want 1", cons_start); end
    checks++; if (front_len !== 4'd5) begin errors++; $display("FAIL pu_len: got %0h want 5", front_len); end
    checks++; if (swap_count !== 16'd1) begin errors++; $display("FAIL pu_swaps: got %0h want 1", swap_count); end
    prod_go = 1'b0;
    tick();
    checks++; if (prod_halt !== 1'b1) begin errors++; $display("FAIL pu_halt_hi: got %0h want 1", prod_halt); end
    checks++; if (cons_start !== 1'b0) begin errors++; $display("FAIL pu_start_once: got %0h want 0", cons_start); end
    tick();
    mbase = wr_adr;
    checks++; if (state_debug !== 3'd0) begin errors++; $display("FAIL pu_fill: got %0h want 0", state_debug); end
    for (int i = 0; i < 5; i++) begin
      rd_adr = 3'(i);
      exp_q.push_back(mdl[fs][i]);
      tick();
      exp_d = exp_q.pop_front();
      checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL pu_read[%0d]: got %0h want %0h", i, rd_data, exp_d); end
    end
  endtask

  task automatic test_refresh;
    for (int a = 6; a <= 8; a++) pwrite(16'(a));
    cons_done = 1'b1;
    tick();
    cons_done = 1'b0;
    checks++; if (cons_start !== 1'b1) begin errors++; $display("FAIL rf_start: got %0h want 1", cons_start); end
    checks++; if (state_debug !== 3'd0) begin errors++; $display("FAIL rf_state: got %0h want 0", state_debug); end
    checks++; if (swap_count !== 16'd1) begin errors++; $display("FAIL rf_swaps: got %0h want 1", swap_count); end
    rd_adr = 3'd0;
    exp_q.push_back(mdl[fs][0]);
    tick();
    exp_d = exp_q.pop_front();
    checks++; if (cons_start !== 1'b0) begin errors++; $display("FAIL rf_pulse: got %0h want 0", cons_start); end
    checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL rf_read: got %0h want %0h", rd_data, exp_d); end
  endtask

  task automatic test_swap_boundary;
    prod_go = 1'b1;
    repeat (2) tick();
    checks++; if (state_debug !== 3'd1) begin errors++; $display("FAIL sb_wait: got %0h want 1", state_debug); end
    cons_done = 1'b1;
    tick();
    cons_done = 1'b0;
    checks++; if (state_debug !== 3'd2) begin errors++; $display("FAIL sb_swap: got %0h want 2", state_debug); end
    tick();
    fs = !fs;
    checks++; if (front_len !== 4'd3) begin errors++; $display("FAIL sb_len: got %0h want 3", front_len); end
    checks++; if (swap_count !== 16'd2) begin errors++; $display("FAIL sb_swaps: got %0h want 2", swap_count); end
    checks++; if (cons_start !== 1'b1) begin errors++; $display("FAIL sb_start: got %0h want 1", cons_start); end
    prod_go = 1'b0;
    repeat (2) tick();
    mbase = wr_adr;
    for (int i = 0; i < 3; i++) begin
      rd_adr = 3'(i);
      exp_q.push_back(mdl[fs][i]);
      tick();
      exp_d = exp_q.pop_front();
      checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL sb_read[%0d]: got %0h want %0h", i, rd_data, exp_d); end
    end
  endtask

  task automatic test_overflow;
    for (int a = 9; a <= 18; a++) pwrite(16'(a));
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ov_flag: got %0h want 1", overflow); end
    prod_go = 1'b1;
    cons_done = 1'b1;
    tick();
    cons_done = 1'b0;
    checks++; if (state_debug !== 3'd1) begin errors++; $display("FAIL ov_ready: got %0h want 1", state_debug); end
    checks++; if (cons_start !== 1'b0) begin errors++; $display("FAIL ov_norefresh: got %0h want 0", cons_start); end
    tick();
    checks++; if (state_debug !== 3'd2) begin errors++; $display("FAIL ov_pend_swap: got %0h want 2", state_debug); end
    tick();
    fs = !fs;
    checks++; if (front_len !== 4'd8) begin errors++; $display("FAIL ov_len: got %0h want 8", front_len); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ov_sticky: got %0h want 1", overflow); end
    prod_go = 1'b0;
    repeat (2) tick();
    mbase = wr_adr;
    for (int i = 0; i < 8; i++) begin
      rd_adr = 3'(i);
      exp_q.push_back(mdl[fs][i]);
      tick();
      exp_d = exp_q.pop_front();
      checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL ov_read[%0d]: got %0h want %0h", i, rd_data, exp_d); end
    end
  endtask

  task automatic test_async_reset;
    prod_go = 1'b1;
    tick();
    cons_done = 1'b1;
    tick();
    cons_done = 1'b0;
    tick();
    checks++; if (state_debug !== 3'd3) begin errors++; $display("FAIL ar_rel_lo: got %0h want 3", state_debug); end
    #2;
    rst_n = 1'b0;
    wr_adr = '0;
    prod_go = 1'b0;
    #1;
    checks++; if (prod_halt !== 1'b1) begin errors++; $display("FAIL ar_halt: got %0h want 1", prod_halt); end
    checks++; if (swap_count !== 16'd0) begin errors++; $display("FAIL ar_swaps: got %0h want 0", swap_count); end
    checks++; if (state_debug !== 3'd0) begin errors++; $display("FAIL ar_state: got %0h want 0", state_debug); end
    checks++; if (cons_start !== 1'b0) begin errors++; $display("FAIL ar_start: got %0h want 0", cons_start); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ar_ovf: got %0h want 0", overflow); end
    repeat (2) tick();
    rst_n = 1'b1;
    fs = 1'b0;
    mbase = '0;
    tick();
  endtask

  task automatic test_wrap;
    prod_go = 1'b1;
    repeat (3) tick();
    fs = !fs;
    checks++; if (front_len !== 4'd0) begin errors++; $display("FAIL wr_empty_len: got %0h want 0", front_len); end
    wr_adr = 16'hFFFE;
    prod_go = 1'b0;
    repeat (2) tick();
    mbase = 16'hFFFE;
    pwrite(16'hFFFF);
    pwrite(16'h0000);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wr_noovf: got %0h want 0", overflow); end
    prod_go = 1'b1;
    cons_done = 1'b1;
    tick();
    cons_done = 1'b0;
    repeat (2) tick();
    fs = !fs;
    checks++; if (front_len !== 4'd2) begin errors++; $display("FAIL wr_len: got %0h want 2", front_len); end
    checks++; if (swap_count !== 16'd2) begin errors++; $display("FAIL wr_swaps: got %0h want 2", swap_count); end
    prod_go = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      rd_adr = 3'(i);
      exp_q.push_back(mdl[fs][i]);
      tick();
      exp_d = exp_q.pop_front();
      checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL wr_read[%0d]: got %0h want %0h", i, rd_data, exp_d); end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_refresh();
    test_swap_boundary();
    test_overflow();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
